// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV flag bit positions and retire-stage states.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } stage_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction executes given NZCV.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_retire_stage.sv
// Post-ALU retire stage: owns NZCV, gates side-effecting writes by the condition,
// emits one retire beat per instruction and parks in HALT after a taken Finished instruction.
module cond_retire_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic              alu_finished,
  input  logic [3:0]        cond,
  input  logic [1:0]        flag_w,
  input  logic [RD_W-1:0]   rd,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              pc_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_write,
  output logic              out_pc_src,
  output logic              out_cond_ex,
  output logic [3:0]        flags_q,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  squashed_cnt
);

  stage_state_e state;
  logic         cond_ex;
  logic         accept;

  // Condition is judged against the flags as they stand before this beat updates them.
  cond_check u_cond_check (
    .flags   (flags_q),
    .cond    (cond),
    .cond_ex (cond_ex)
  );

  // No skid buffer: a held beat blocks intake until downstream takes it.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_write <= 1'b0;
      out_pc_src    <= 1'b0;
      out_cond_ex   <= 1'b0;
      flags_q       <= 4'b0000;
      retired_cnt   <= '0;
      squashed_cnt  <= '0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_result    <= alu_result;
      out_rd        <= rd;
      out_reg_write <= reg_write && cond_ex;
      out_mem_write <= mem_write && cond_ex;
      out_pc_src    <= pc_src && cond_ex;
      out_cond_ex   <= cond_ex;
      if (cond_ex) begin
        if (flag_w[1]) flags_q[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
        if (flag_w[0]) flags_q[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
        if (retired_cnt != {CNT_W{1'b1}}) retired_cnt <= retired_cnt + CNT_W'(1);
        if (alu_finished) state <= HALT;
      end else begin
        if (squashed_cnt != {CNT_W{1'b1}}) squashed_cnt <= squashed_cnt + CNT_W'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_retire_stage.sv
// Scoreboard bench for cond_retire_stage: a flag/counter reference model predicts each
// retire beat; a monitor compares beats as they hand off downstream.
module tb_cond_retire_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result = '0;
  logic [3:0]        alu_flags = '0;
  logic              alu_finished = 1'b0;
  logic [3:0]        cond = '0;
  logic [1:0]        flag_w = '0;
  logic [RD_W-1:0]   rd = '0;
  logic              reg_write = 1'b0;
  logic              mem_write = 1'b0;
  logic              pc_src = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  logic              out_mem_write;
  logic              out_pc_src;
  logic              out_cond_ex;
  logic [3:0]        flags_q;
  logic              halted;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  squashed_cnt;

  cond_retire_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_finished(alu_finished),
    .cond(cond), .flag_w(flag_w), .rd(rd),
    .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_pc_src(out_pc_src),
    .out_cond_ex(out_cond_ex), .flags_q(flags_q), .halted(halted),
    .retired_cnt(retired_cnt), .squashed_cnt(squashed_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic [3:0]  ctrl;   // {cond_ex, reg_write, mem_write, pc_src}
    logic [3:0]  flags;
    int          ret;
    int          sq;
    logic        halt;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] m_flags;
  int         m_ret, m_sq;
  bit         m_halt, m_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conditions come in pairs: the odd code is the negation of the even code below it.
  function automatic bit cond_pass(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, base;
    logic [2:0] pair;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    pair = c[3:1];
    case (pair)
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic model_clear();
    m_flags = 4'b0000; m_ret = 0; m_sq = 0; m_halt = 0; m_pend = 0;
    sb.delete();
  endtask

  // One cycle: drive inputs, check visible state, predict the edge.
  task automatic step(input logic v, input logic [31:0] res, input logic [3:0] fl,
                      input logic fin, input logic [3:0] c, input logic [1:0] fw,
                      input logic [3:0] r, input logic rw, input logic mw,
                      input logic ps, input logic ordy);
    bit exp_rdy, cex;
    beat_t b;
    @(negedge clk);
    in_valid = v; alu_result = res; alu_flags = fl; alu_finished = fin;
    cond = c; flag_w = fw; rd = r; reg_write = rw; mem_write = mw; pc_src = ps;
    out_ready = ordy;
    #1;
    exp_rdy = !m_halt && (!m_pend || ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_pend));
    chk("flags_q", 64'(flags_q), 64'(m_flags));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("counters", {48'(retired_cnt), 16'(squashed_cnt)}, {48'(m_ret), 16'(m_sq)});
    if (v && exp_rdy) begin
      cex = cond_pass(m_flags, c);
      if (cex) begin
        if (fw[1]) m_flags[3:2] = fl[3:2];
        if (fw[0]) m_flags[1:0] = fl[1:0];
        m_ret = sat_inc(m_ret);
        if (fin) m_halt = 1;
      end else begin
        m_sq = sat_inc(m_sq);
      end
      b.res = res; b.rd = r; b.ctrl = {cex, rw && cex, mw && cex, ps && cex};
      b.flags = m_flags; b.ret = m_ret; b.sq = m_sq; b.halt = m_halt;
      sb.push_back(b);
      m_pend = 1;
    end else if (m_pend && ordy) begin
      m_pend = 0;
    end
  endtask

  // Asynchronous reset asserted between edges with a beat on the input.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("reset_state",
        {10'd0, out_valid, out_result, out_rd, out_reg_write, out_mem_write, out_pc_src,
         out_cond_ex, flags_q, halted, retired_cnt, squashed_cnt}, 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every beat at the moment downstream takes it.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=beat required=none at %0t", $time);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_result", 64'(out_result), 64'(e.res));
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_ctrl", 64'({out_cond_ex, out_reg_write, out_mem_write, out_pc_src}), 64'(e.ctrl));
        chk("beat_flags", 64'(flags_q), 64'(e.flags));
        chk("beat_counts", {48'(retired_cnt), 16'(squashed_cnt)}, {48'(e.ret), 16'(e.sq)});
        chk("beat_halted", 64'(halted), 64'(e.halt));
      end
    end
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Preload flags to 1111, then reset mid-beat.
    step(1, 32'h1, 4'b1111, 0, 4'hE, 2'b11, 4'd1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("preload_flags", 64'(flags_q), 64'hF);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // CMP 5,5 then EQ, then NE squashed.
    step(1, 32'h0, 4'b0110, 0, 4'hE, 2'b11, 4'd0, 0, 0, 0, 1);
    step(1, 32'h5, 4'b0000, 0, 4'h0, 2'b00, 4'd3, 1, 0, 0, 1);
    step(1, 32'h7, 4'b1000, 0, 4'h1, 2'b11, 4'd4, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Backpressure: two beats offered while downstream stalls.
    step(1, 32'hA1, 4'b0000, 0, 4'hE, 2'b00, 4'd5, 1, 0, 0, 0);
    step(1, 32'hB2, 4'b0000, 0, 4'hE, 2'b00, 4'd6, 1, 0, 0, 0);
    step(1, 32'hB2, 4'b0000, 0, 4'hE, 2'b00, 4'd6, 1, 0, 0, 0);
    step(1, 32'hB2, 4'b0000, 0, 4'hE, 2'b00, 4'd6, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Failed-condition Finished does not halt; taken one does.
    step(1, 32'h11, 4'b0000, 1, 4'hF, 2'b00, 4'd2, 0, 0, 1, 1);
    step(1, 32'hDEADBEEF, 4'b0000, 1, 4'hE, 2'b00, 4'd7, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, $urandom, 4'($urandom), 0, 4'hE, 2'b11, 4'd1, 1, 0, 0, 1);
    do_reset();

    // Random traffic; counters saturate along the way.
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 5) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
             $urandom_range(0, 39) == 0, 4'($urandom), 2'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-beat with saturated counters.
    for (int i = 0; i < 20; i++) step(1, $urandom, 4'($urandom), 0, 4'hE, 2'b00, 4'd0, 0, 0, 0, 1);
    chk("sat_retired", 64'(retired_cnt), 64'(CNT_MAX));
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
